// File: rtl/apb_uart_fifo.sv
// apb_uart_fifo: APB3 slave UART with TX/RX FIFOs, optional parity,
// one or two stop bits, sticky error flags, PSLVERR reporting and a
// maskable level interrupt.
//
// Ports:
//   PCLK, PRESET          clock, asynchronous active-high reset
//   PADDR/PSEL/PENABLE/   APB3 slave, zero wait states; PADDR is a word index
//   PWRITE/PWDATA
//   PRDATA/PREADY/PSLVERR read data, always-ready, per-access error
//   tx_serial             UART transmit line, idle high
//   rx_serial             UART receive line, asynchronous to PCLK
//   irq                   registered OR of the enabled interrupt sources

// Byte FIFO with an extra wrap bit on each pointer so full and empty
// can be told apart. The head is read combinationally so RXDATA can be
// returned in the same APB access phase.
module apb_uart_fifo_buf #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        clr,
  input  logic        push,
  input  logic        pop,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic        empty,
  output logic        full,
  output logic [AW:0] level
);
  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr_reg;
  logic [AW:0] rd_ptr_reg;
  logic        do_push;
  logic        do_pop;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                 (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
  assign level = wr_ptr_reg - rd_ptr_reg;
  assign dout  = mem[rd_ptr_reg[AW-1:0]];

  // A push into a full FIFO is accepted only when the head leaves on the
  // same edge; a pop from an empty FIFO never happens.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else if (clr) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge PCLK) begin
    if (do_push && !clr) mem[wr_ptr_reg[AW-1:0]] <= din;
  end
endmodule

module apb_uart_fifo #(
  parameter int PADDR_WIDTH    = 32,
  parameter int PDATA_WIDTH    = 32,
  parameter int FIFO_DEPTH     = 8,
  parameter int DEFAULT_BAUDIV = 10417
) (
  input  logic                   PCLK,
  input  logic                   PRESET,
  input  logic [PADDR_WIDTH-1:0] PADDR,
  input  logic                   PSEL,
  input  logic                   PENABLE,
  input  logic                   PWRITE,
  input  logic [PDATA_WIDTH-1:0] PWDATA,
  output logic [PDATA_WIDTH-1:0] PRDATA,
  output logic                   PREADY,
  output logic                   PSLVERR,
  output logic                   tx_serial,
  input  logic                   rx_serial,
  output logic                   irq
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

  // Configuration and status registers
  logic [6:0]  ctrl_reg;
  logic [15:0] baudiv_reg;
  logic [2:0]  int_en_reg;
  logic        overrun_reg, parity_err_reg, frame_err_reg;
  logic        irq_reg;

  wire tx_en    = ctrl_reg[0];
  wire rx_en    = ctrl_reg[1];
  wire par_en   = ctrl_reg[4];
  wire par_odd  = ctrl_reg[5];
  wire two_stop = ctrl_reg[6];

  // APB decode
  logic access, wr_acc, rd_acc;
  logic sel_ctrl, sel_stat, sel_tx, sel_rx, sel_baud, sel_inten;
  logic [15:0] rd_val;
  logic        apb_err;
  logic        tx_clr, rx_clr, stat_wr, tx_push, rx_pop;

  // FIFO interfaces
  logic [7:0]  txf_dout, rxf_dout;
  logic        txf_empty, txf_full, rxf_empty, rxf_full;
  logic [AW:0] tx_level_unused, rxf_level;
  logic        tx_pop, rx_push;
  logic [15:0] stat_val;
  logic        unused_bits;

  // TX FSM state
  tx_state_t   tx_state_reg;
  logic [15:0] tx_cnt_reg;
  logic [2:0]  tx_idx_reg;
  logic [7:0]  tx_shift_reg;
  logic        tx_par_reg, tx_stop_idx_reg, tx_serial_reg;
  logic        tx_last_stop, tx_busy;

  // RX path state
  logic        rx_s1_reg, rx_s2_reg, rx_prev_reg;
  rx_state_t   rx_state_reg;
  logic [15:0] rx_cnt_reg;
  logic [2:0]  rx_idx_reg;
  logic [7:0]  rx_shift_reg;
  logic        rx_fall, rx_sample, rx_push_req;
  logic        ovr_set, par_set, frm_set;

  assign access    = PSEL && PENABLE;
  assign wr_acc    = access && PWRITE;
  assign rd_acc    = access && !PWRITE;
  assign sel_ctrl  = (PADDR == PADDR_WIDTH'(0));
  assign sel_stat  = (PADDR == PADDR_WIDTH'(1));
  assign sel_tx    = (PADDR == PADDR_WIDTH'(2));
  assign sel_rx    = (PADDR == PADDR_WIDTH'(3));
  assign sel_baud  = (PADDR == PADDR_WIDTH'(4));
  assign sel_inten = (PADDR == PADDR_WIDTH'(5));

  assign tx_busy  = (tx_state_reg != TX_IDLE);
  assign stat_val = {8'(rxf_level), frame_err_reg, parity_err_reg, overrun_reg,
                     tx_busy, rxf_full, rxf_empty, txf_full, txf_empty};

  always_comb begin
    rd_val  = '0;
    apb_err = 1'b0;
    if (access) begin
      if (sel_ctrl) begin
        if (!PWRITE) rd_val = {9'b0, ctrl_reg};
      end else if (sel_stat) begin
        if (!PWRITE) rd_val = stat_val;
      end else if (sel_tx) begin
        // A full TX FIFO still accepts a byte if the FSM pops on this edge.
        if (!PWRITE || (txf_full && !tx_pop)) apb_err = 1'b1;
      end else if (sel_rx) begin
        if (PWRITE || rxf_empty) apb_err = 1'b1;
        else rd_val = {8'h00, rxf_dout};
      end else if (sel_baud) begin
        if (PWRITE) begin
          if (PWDATA[15:0] < 16'd2) apb_err = 1'b1;
        end else begin
          rd_val = baudiv_reg;
        end
      end else if (sel_inten) begin
        if (!PWRITE) rd_val = {13'b0, int_en_reg};
      end else begin
        apb_err = 1'b1;
      end
    end
  end

  assign PRDATA  = rd_acc ? PDATA_WIDTH'(rd_val) : '0;
  assign PSLVERR = apb_err;
  assign PREADY  = 1'b1;

  assign tx_clr  = wr_acc && sel_ctrl && PWDATA[2];
  assign rx_clr  = wr_acc && sel_ctrl && PWDATA[3];
  assign stat_wr = wr_acc && sel_stat;
  assign tx_push = wr_acc && sel_tx && !apb_err;
  assign rx_pop  = rd_acc && sel_rx && !rxf_empty;

  assign unused_bits = &{1'b0, PWDATA[PDATA_WIDTH-1:16], tx_level_unused};

  // Register file
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      ctrl_reg       <= '0;
      baudiv_reg     <= 16'(DEFAULT_BAUDIV);
      int_en_reg     <= '0;
      overrun_reg    <= 1'b0;
      parity_err_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      irq_reg        <= 1'b0;
    end else begin
      // Clear bits are one-shot strobes and are never stored.
      if (wr_acc && sel_ctrl) ctrl_reg <= {PWDATA[6:4], 2'b00, PWDATA[1:0]};
      if (wr_acc && sel_baud && !apb_err) baudiv_reg <= PWDATA[15:0];
      if (wr_acc && sel_inten) int_en_reg <= PWDATA[2:0];
      // A new error event wins over a simultaneous write-1-to-clear.
      overrun_reg    <= (overrun_reg    && !(stat_wr && PWDATA[5])) || ovr_set;
      parity_err_reg <= (parity_err_reg && !(stat_wr && PWDATA[6])) || par_set;
      frame_err_reg  <= (frame_err_reg  && !(stat_wr && PWDATA[7])) || frm_set;
      irq_reg <= (int_en_reg[0] && !rxf_empty) ||
                 (int_en_reg[1] && txf_empty) ||
                 (int_en_reg[2] && (overrun_reg || parity_err_reg || frame_err_reg));
    end
  end
  assign irq = irq_reg;

  apb_uart_fifo_buf #(.DEPTH(FIFO_DEPTH), .AW(AW)) u_txf (
    .PCLK(PCLK), .PRESET(PRESET), .clr(tx_clr), .push(tx_push), .pop(tx_pop),
    .din(PWDATA[7:0]), .dout(txf_dout), .empty(txf_empty), .full(txf_full),
    .level(tx_level_unused)
  );

  apb_uart_fifo_buf #(.DEPTH(FIFO_DEPTH), .AW(AW)) u_rxf (
    .PCLK(PCLK), .PRESET(PRESET), .clr(rx_clr), .push(rx_push), .pop(rx_pop),
    .din(rx_shift_reg), .dout(rxf_dout), .empty(rxf_empty), .full(rxf_full),
    .level(rxf_level)
  );

  // TX: a new frame starts from IDLE or straight out of the final stop bit.
  assign tx_last_stop = (tx_state_reg == TX_STOP) && (tx_cnt_reg == 16'd0) &&
                        (!two_stop || tx_stop_idx_reg);
  assign tx_pop = tx_en && !txf_empty && !tx_clr &&
                  ((tx_state_reg == TX_IDLE) || tx_last_stop);

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      tx_state_reg    <= TX_IDLE;
      tx_cnt_reg      <= '0;
      tx_idx_reg      <= '0;
      tx_shift_reg    <= '0;
      tx_par_reg      <= 1'b0;
      tx_stop_idx_reg <= 1'b0;
      tx_serial_reg   <= 1'b1;
    end else if (tx_pop) begin
      tx_state_reg  <= TX_START;
      tx_shift_reg  <= txf_dout;
      tx_par_reg    <= (^txf_dout) ^ par_odd;
      tx_cnt_reg    <= baudiv_reg - 16'd1;
      tx_serial_reg <= 1'b0;
    end else if (tx_state_reg != TX_IDLE) begin
      if (tx_cnt_reg != 16'd0) begin
        tx_cnt_reg <= tx_cnt_reg - 16'd1;
      end else begin
        // Bit boundary: reload from the current BAUDIV for the next bit.
        tx_cnt_reg <= baudiv_reg - 16'd1;
        unique case (tx_state_reg)
          TX_START: begin
            tx_state_reg  <= TX_DATA;
            tx_idx_reg    <= '0;
            tx_serial_reg <= tx_shift_reg[0];
          end
          TX_DATA: begin
            if (tx_idx_reg == 3'd7) begin
              tx_stop_idx_reg <= 1'b0;
              if (par_en) begin
                tx_state_reg  <= TX_PARITY;
                tx_serial_reg <= tx_par_reg;
              end else begin
                tx_state_reg  <= TX_STOP;
                tx_serial_reg <= 1'b1;
              end
            end else begin
              tx_idx_reg    <= tx_idx_reg + 3'd1;
              tx_shift_reg  <= {1'b0, tx_shift_reg[7:1]};
              tx_serial_reg <= tx_shift_reg[1];
            end
          end
          TX_PARITY: begin
            tx_state_reg    <= TX_STOP;
            tx_stop_idx_reg <= 1'b0;
            tx_serial_reg   <= 1'b1;
          end
          TX_STOP: begin
            if (two_stop && !tx_stop_idx_reg) tx_stop_idx_reg <= 1'b1;
            else tx_state_reg <= TX_IDLE;
            tx_serial_reg <= 1'b1;
          end
          default: tx_state_reg <= TX_IDLE;
        endcase
      end
    end
  end
  assign tx_serial = tx_serial_reg;

  // RX synchroniser plus one more flop for falling-edge detection.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      rx_s1_reg   <= 1'b1;
      rx_s2_reg   <= 1'b1;
      rx_prev_reg <= 1'b1;
    end else begin
      rx_s1_reg   <= rx_serial;
      rx_s2_reg   <= rx_s1_reg;
      rx_prev_reg <= rx_s2_reg;
    end
  end

  assign rx_fall     = rx_prev_reg && !rx_s2_reg;
  assign rx_sample   = rx_en && (rx_state_reg != RX_IDLE) && (rx_cnt_reg == 16'd0);
  assign rx_push_req = rx_sample && (rx_state_reg == RX_STOP) && rx_s2_reg;
  assign rx_push     = rx_push_req;
  // The FIFO accepts a push on full only alongside a pop; otherwise it is lost.
  assign ovr_set     = rx_push_req && rxf_full && !rx_pop;
  assign frm_set     = rx_sample && (rx_state_reg == RX_STOP) && !rx_s2_reg;
  assign par_set     = rx_sample && (rx_state_reg == RX_PARITY) &&
                       (rx_s2_reg != ((^rx_shift_reg) ^ par_odd));

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      rx_state_reg <= RX_IDLE;
      rx_cnt_reg   <= '0;
      rx_idx_reg   <= '0;
      rx_shift_reg <= '0;
    end else if (!rx_en) begin
      rx_state_reg <= RX_IDLE;
    end else if (rx_state_reg == RX_IDLE) begin
      if (rx_fall) begin
        rx_state_reg <= RX_START;
        rx_cnt_reg   <= (baudiv_reg >> 1) - 16'd1;
      end
    end else if (rx_cnt_reg != 16'd0) begin
      rx_cnt_reg <= rx_cnt_reg - 16'd1;
    end else begin
      rx_cnt_reg <= baudiv_reg - 16'd1;
      unique case (rx_state_reg)
        RX_START: begin
          // Line back high at mid-start: a glitch, not a frame.
          if (rx_s2_reg) rx_state_reg <= RX_IDLE;
          else begin
            rx_state_reg <= RX_DATA;
            rx_idx_reg   <= '0;
          end
        end
        RX_DATA: begin
          rx_shift_reg <= {rx_s2_reg, rx_shift_reg[7:1]};
          if (rx_idx_reg == 3'd7) rx_state_reg <= par_en ? RX_PARITY : RX_STOP;
          else rx_idx_reg <= rx_idx_reg + 3'd1;
        end
        RX_PARITY: rx_state_reg <= RX_STOP;
        RX_STOP:   rx_state_reg <= RX_IDLE;
        default:   rx_state_reg <= RX_IDLE;
      endcase
    end
  end
endmodule

// File: doc/apb_uart_fifo.md
Name: apb_uart_fifo

Overview:
- APB3 slave UART, successor to the single-byte APB UART wrapper.
- Adds parametrised TX/RX FIFOs, optional parity, selectable stop bits, sticky error flags, PSLVERR reporting and a maskable interrupt.
- Sits on the peripheral APB bus; tx_serial/rx_serial go to the pads.

Parameters:
- PADDR_WIDTH, 32, APB address width.
- PDATA_WIDTH, 32, PWDATA/PRDATA width (>=16).
- FIFO_DEPTH, 8, entries per FIFO; power of 2, >=2.
- DEFAULT_BAUDIV, 10417, reset value of BAUDIV (PCLK cycles per bit; 9600 baud at 100 MHz).

Ports:
- PCLK  in  1  clock
- PRESET  in  1  asynchronous active-high reset
- PADDR  in  PADDR_WIDTH  word index of register
- PSEL  in  1  slave select
- PENABLE  in  1  access phase
- PWRITE  in  1  1=write
- PWDATA  in  PDATA_WIDTH  write data
- PRDATA  out  PDATA_WIDTH  read data
- PREADY  out  1  always 1
- PSLVERR  out  1  error on current access
- tx_serial  out  1  UART TX, idle high
- rx_serial  in  1  UART RX, asynchronous
- irq  out  1  level interrupt

Behaviour:
- Reset: tx_serial=1, PRDATA=0, PSLVERR=0, irq=0, CTRL=0, INT_EN=0, BAUDIV=DEFAULT_BAUDIV, FIFOs empty, sticky flags 0, both FSMs IDLE.
- APB: zero wait states. Transfer commits on the PCLK edge where PSEL&PENABLE. PRDATA/PSLVERR are combinational during the access phase and 0 otherwise.
- Register map:
  - 0 CTRL RW: [0] tx_en, [1] rx_en, [2] tx_clr, [3] rx_clr (self-clearing, read 0), [4] par_en, [5] par_odd, [6] two_stop.
  - 1 STAT: [0] txf_empty, [1] txf_full, [2] rxf_empty, [3] rxf_full, [4] tx_busy, [5] overrun, [6] parity_err, [7] frame_err, [15:8] rx level. Writing 1 to bits [7:5] clears them; other bits are RO.
  - 2 TXDATA WO: push PWDATA[7:0]. If FIFO full: drop and PSLVERR=1.
  - 3 RXDATA RO: PRDATA[7:0]=FIFO head; pop at commit edge. If empty: PRDATA=0, PSLVERR=1, no pop.
  - 4 BAUDIV RW [15:0]: write <2 is ignored and PSLVERR=1.
  - 5 INT_EN RW: [0] rx_not_empty, [1] txf_empty, [2] any sticky error.
- Unmapped address, write to RXDATA or read of TXDATA: PSLVERR=1, no side effect, PRDATA=0.
- irq is registered: OR of enabled sources, 1 cycle after the source changes.
- FIFOs: read/write pointers with an extra wrap bit.
  - Clear has priority over push/pop.
  - Simultaneous push and pop when full: both happen, level unchanged, no overrun.
  - Simultaneous push and pop when empty: push only.
- Baud: each FSM has a 16-bit bit-counter reloaded from BAUDIV at each bit start. A BAUDIV change applies from the next bit.
- TX FSM: IDLE→START→DATA(8 bits, LSB first)→[PARITY if par_en]→STOP(1 or 2 bits)→IDLE.
  - Leaves IDLE when tx_en and TX FIFO not empty. Pops the head on the same edge; tx_serial goes low the next cycle.
  - Each bit lasts exactly BAUDIV cycles.
  - Parity bit: XOR of data (even), inverted if par_odd.
  - Back-to-back frames: STOP→START with no idle gap when the FIFO is non-empty.
  - tx_en cleared mid-frame: current frame completes, then the FSM stays IDLE.
  - tx_busy=1 whenever not IDLE.
- RX path: rx_serial passes a 2-flop synchroniser, adding 2 cycles of latency.
- RX FSM: IDLE→START→DATA→[PARITY]→STOP→IDLE.
  - IDLE: leave on a falling edge, only while rx_en.
  - START: sample at BAUDIV/2. If high, treat as a glitch and return to IDLE.
  - DATA, PARITY and STOP bits: sample every BAUDIV cycles after the start sample.
  - Parity mismatch: set parity_err; the byte is still pushed.
  - Stop bit sampled 0: set frame_err, discard the byte. Only the first stop bit is checked.
  - Push on RX FIFO full: set overrun, drop the byte.
  - Return to IDLE right after the stop sample, so the next start is detectable.
  - rx_en cleared mid-frame: abort to IDLE, no push.
- PRESET mid-frame: immediate return to reset state; tx_serial=1 asynchronously.

Test Plan:
- BAUDIV=16, push 0x55, CTRL=0x01 -> tx_serial shows 0,1,0,1,0,1,0,1,0,1 with each bit 16 cycles; tx_busy falls; STAT[0]=1.
- Push 9 bytes with FIFO_DEPTH=8 and tx_en=0 -> 9th write returns PSLVERR=1; STAT[1]=1; enabling TX sends exactly 8 frames back-to-back.
- rx_en, par_en, par_odd, BAUDIV=16, drive frame 0xAF with correct odd parity and stop=1 -> RXDATA=0xAF, rx level=1, parity_err=0. Repeat with a wrong parity bit -> parity_err=1 and byte present.
- Drive 9 frames with no reads -> overrun=1, first 8 bytes read back in order, 9th RXDATA read gives PSLVERR=1. Write 0x20 to STAT -> overrun=0.
- Stop bit driven 0 -> frame_err=1, rx level unchanged. 4-cycle low glitch on idle line -> no frame received.
- INT_EN=0x1, receive one byte -> irq=1; read RXDATA -> irq=0 one cycle later. Reads of address 7 and BAUDIV write of 1 -> PSLVERR=1, BAUDIV unchanged.
